// File: rtl/mult_bus_ctrl.sv
// mult_bus_ctrl: J1 I/O-bus front end that launches the 16x16 multiplier core and captures its product
// Ports: clk/rst (sync, active-high); cs/rd/wr/addr/d_in bus access, d_out registered read data (1-cycle latency);
//        irq one-cycle pulse per finished op; m_A/m_B/m_init drive the core, m_pp/m_done come back from it.
// Map: 0 A, 1 B, 2 CTRL(wr bit0=start)/STATUS {ovr,err,done,busy}, 3 RESULT lo, 4 RESULT hi, 5-7 read 0.
module mult_bus_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic        irq,
  output logic [15:0] m_A,
  output logic [15:0] m_B,
  output logic        m_init,
  input  logic [31:0] m_pp,
  input  logic        m_done
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
  state_t r_state, w_next;
  logic [15:0] r_a, r_b, w_rdata;
  logic [31:0] r_res;
  logic [7:0]  r_tcnt;
  logic [3:0]  r_icnt;
  logic r_done, r_err, r_ovr, r_done_q;
  logic w_rd, w_wr, w_busy, w_cmd, w_start, w_ok, w_to;
  // a simultaneous read+write is a write only
  assign w_rd    = cs & rd & ~wr;
  assign w_wr    = cs & wr;
  assign w_busy  = r_state != IDLE;
  assign w_cmd   = w_wr && addr == 3'd2 && d_in[0];
  assign w_start = w_cmd && !w_busy;
  // a done edge beats a timeout landing on the same cycle
  assign w_ok    = r_state == WAIT && m_done && !r_done_q;
  assign w_to    = r_state == WAIT && !w_ok && r_tcnt == 8'd1;
  assign m_A     = r_a;
  assign m_B     = r_b;
  assign m_init  = r_state == LAUNCH;
  assign w_rdata = addr == 3'd0 ? r_a :
                   addr == 3'd1 ? r_b :
                   addr == 3'd2 ? {12'b0, r_ovr, r_err, r_done, w_busy} :
                   addr == 3'd3 ? r_res[15:0] :
                   addr == 3'd4 ? r_res[31:16] : 16'h0;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && w_start)         ? LAUNCH :
             (r_state == LAUNCH && r_icnt == 4'd0) ? WAIT :
             (w_ok || w_to)                        ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      d_out    <= '0;
      irq      <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ovr    <= 1'b0;
      r_tcnt   <= '0;
      r_icnt   <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done_q <= m_done;
      irq      <= w_ok || w_to;
      if (w_rd) d_out <= w_rdata;
      if (w_wr && addr == 3'd0 && !w_busy) r_a <= d_in;
      if (w_wr && addr == 3'd1 && !w_busy) r_b <= d_in;
      // status reads return the flags first, then clear them; a new event on the same edge wins
      if (w_busy && (w_cmd || (w_wr && (addr == 3'd0 || addr == 3'd1)))) r_ovr <= 1'b1;
      else if (w_rd && addr == 3'd2) r_ovr <= 1'b0;
      if (w_to) r_err <= 1'b1;
      else if (w_start || (w_rd && addr == 3'd2)) r_err <= 1'b0;
      if (w_ok) r_done <= 1'b1;
      else if (w_start || (w_rd && addr == 3'd4)) r_done <= 1'b0;
      if (w_ok) r_res <= m_pp;
      if (w_start) r_icnt <= 4'(INIT_CYCLES - 1);
      else if (r_state == LAUNCH && r_icnt != 4'd0) r_icnt <= r_icnt - 4'd1;
      if (r_state == LAUNCH && r_icnt == 4'd0) r_tcnt <= 8'(TIMEOUT);
      else if (r_state == WAIT) r_tcnt <= r_tcnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_mult_bus_ctrl.sv
// tb_mult_bus_ctrl: randomized scoreboard bench for mult_bus_ctrl with a transaction-level reference model
module tb_mult_bus_ctrl;
  localparam int INIT = 2;
  localparam int TO   = 64;
  logic        clk = 1'b0, rst = 1'b1, cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] d_in = '0;
  logic [15:0] d_out, m_A, m_B;
  logic        irq, m_init;
  logic [31:0] m_pp = '0;
  logic        m_done = 1'b0;
  mult_bus_ctrl #(.INIT_CYCLES(INIT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr), .d_in(d_in),
    .d_out(d_out), .irq(irq), .m_A(m_A), .m_B(m_B), .m_init(m_init),
    .m_pp(m_pp), .m_done(m_done)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  logic [15:0] exp_q[$];
  string       name_q[$];
  int          init_q[$];
  int  cyc_n = 0, irq_cnt = 0, irq_cyc = 0, init_len = 0;
  bit  rd_seen = 0, rst_seen = 1, irq_prev = 0;
  logic [15:0] last_dout = '0;
  always @(posedge clk) begin
    cyc_n++;
    rd_seen  = cs & rd & ~wr;
    rst_seen = rst;
  end
  always @(negedge clk) begin
    if (!rst_seen) begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read actual=%h required=none", d_out);
        end else chk(name_q.pop_front(), d_out, exp_q.pop_front());
      end else chk("dout_hold", d_out, last_dout);
    end
    last_dout = d_out;
    if (irq) begin
      chk("irq_width", irq_prev, 0);
      irq_cnt++;
      irq_cyc = cyc_n;
    end
    irq_prev = irq;
    if (m_init) init_len++;
    else if (init_len != 0) begin
      init_q.push_back(init_len);
      init_len = 0;
    end
  end
  bit core_en = 0;
  int core_dly = 0;
  initial begin
    int cnt;
    bit armed;
    cnt = 0;
    armed = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!m_done) m_pp = $urandom;
      if (m_init) begin
        cnt = 0;
        armed = core_en;
        m_done = 1'b0;
      end else if (armed) begin
        cnt++;
        if (cnt == core_dly) begin
          m_done = 1'b1;
          m_pp = {16'b0, m_A} * {16'b0, m_B};
          armed = 0;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  logic [15:0] ma = '0, mb = '0;
  logic [31:0] mres = '0;
  bit mdone = 0, merr = 0, movr = 0;
  int start_cyc = 0, irq0 = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    cs = 1; wr = 1; rd = 0; addr = a; d_in = d;
    tick();
    cs = 0; wr = 0;
  endtask
  task automatic bus_rd(input logic [2:0] a, input logic [15:0] e, input string n);
    cs = 1; rd = 1; wr = 0; addr = a;
    exp_q.push_back(e);
    name_q.push_back(n);
    tick();
    cs = 0; rd = 0;
  endtask
  task automatic rd_status(input string n);
    bus_rd(3'd2, {12'b0, movr, merr, mdone, 1'b0}, n);
    movr = 0;
    merr = 0;
  endtask
  task automatic rd_res();
    bus_rd(3'd3, mres[15:0], "res_lo");
    bus_rd(3'd4, mres[31:16], "res_hi");
    mdone = 0;
  endtask
  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    bus_wr(3'd0, a);
    ma = a;
    bus_wr(3'd1, b);
    mb = b;
  endtask
  task automatic launch(input bit en, input int dly);
    core_en = en;
    core_dly = dly;
    init_q.delete();
    irq0 = irq_cnt;
    bus_wr(3'd2, 16'($urandom) | 16'h1);
    start_cyc = cyc_n;
    mdone = 0;
    merr = 0;
  endtask
  task automatic finish_op();
    bit ok;
    int lat;
    for (int i = 0; i < 300 && irq_cnt == irq0; i++) tick();
    chk("irq_seen", irq_cnt - irq0, 1);
    ok  = core_en && core_dly <= TO;
    lat = ok ? INIT + core_dly : INIT + TO;
    chk("irq_latency", irq_cyc - start_cyc, lat);
    if (ok) begin
      mdone = 1;
      mres = {16'b0, ma} * {16'b0, mb};
    end else merr = 1;
    tick();
    tick();
    chk("irq_single", irq_cnt - irq0, 1);
    chk("init_pulses", init_q.size(), 1);
    if (init_q.size() != 0) chk("init_len", init_q.pop_front(), INIT);
  endtask
  initial begin
    repeat (3) tick();
    rst = 0;
    chk("rst_dout", d_out, 0);
    chk("rst_irq", irq, 0);
    chk("rst_init", m_init, 0);
    chk("rst_mA", m_A, 0);
    chk("rst_mB", m_B, 0);
    bus_rd(3'd0, 16'h0, "rst_a");
    bus_rd(3'd1, 16'h0, "rst_b");
    rd_status("rst_status");
    rd_res();
    bus_rd(3'd7, 16'h0, "rst_addr7");
    // basic multiply
    set_ops(16'h0005, 16'h0003);
    chk("mA_drive", m_A, 16'h0005);
    chk("mB_drive", m_B, 16'h0003);
    launch(1, 17);
    finish_op();
    rd_status("basic_status");
    rd_res();
    rd_status("basic_status_clr");
    // max operands
    set_ops(16'hFFFF, 16'hFFFF);
    launch(1, 17);
    finish_op();
    rd_res();
    // timeout keeps the previous result
    set_ops(16'h0102, 16'h0304);
    launch(0, 0);
    finish_op();
    rd_status("to_status");
    rd_status("to_status_clr");
    rd_res();
    // overrun: writes to A and a second start while waiting
    set_ops(16'h0021, 16'h0042);
    launch(1, 17);
    repeat (INIT + 6) tick();
    bus_wr(3'd0, 16'h1234);
    movr = 1;
    bus_wr(3'd2, 16'h0001);
    bus_rd(3'd0, ma, "ovr_a_kept");
    finish_op();
    rd_status("ovr_status");
    rd_res();
    // start landing on the completion edge is an overrun
    set_ops(16'h0007, 16'h0009);
    launch(1, 10);
    repeat (INIT + 10 - 1) tick();
    bus_wr(3'd2, 16'h0001);
    movr = 1;
    finish_op();
    rd_status("edge_start_status");
    rd_res();
    // start with bit0 clear does nothing
    init_q.delete();
    irq0 = irq_cnt;
    bus_wr(3'd2, 16'hFFFE);
    repeat (10) tick();
    chk("nostart_init", init_q.size(), 0);
    chk("nostart_irq", irq_cnt - irq0, 0);
    rd_status("nostart_status");
    // reset mid-WAIT drops everything
    set_ops(16'h00AA, 16'h0055);
    launch(1, 17);
    repeat (INIT + 5) tick();
    rst = 1;
    tick();
    rst = 0;
    ma = 0; mb = 0; mres = 0; mdone = 0; merr = 0; movr = 0;
    chk("midrst_dout", d_out, 0);
    chk("midrst_init", m_init, 0);
    chk("midrst_mA", m_A, 0);
    repeat (40) tick();
    chk("midrst_no_irq", irq_cnt - irq0, 0);
    rd_status("midrst_status");
    rd_res();
    // done rising on the final timeout cycle, and one cycle too late
    set_ops(16'h1111, 16'h000F);
    launch(1, TO);
    finish_op();
    rd_status("bnd_status");
    rd_res();
    set_ops(16'h2222, 16'h0003);
    launch(1, TO + 1);
    finish_op();
    rd_status("late_status");
    rd_res();
    // unmapped addresses
    bus_wr(3'd5, 16'hBEEF);
    bus_rd(3'd5, 16'h0, "addr5");
    bus_rd(3'd6, 16'h0, "addr6");
    // randomized operations
    for (int k = 0; k < 8; k++) begin
      set_ops(16'($urandom), 16'($urandom));
      bus_rd(3'd0, ma, "rnd_a");
      bus_rd(3'd1, mb, "rnd_b");
      launch($urandom_range(0, 3) != 0, $urandom_range(1, 70));
      finish_op();
      rd_status("rnd_status");
      rd_res();
    end
    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
